// File: rtl/ou_display_if.sv
// ou_display_if: display-unit bus; master drives load/value and receives busy/seg/an, slave is ou_display
interface ou_display_if #(
  parameter int W = 8,
  parameter int DIGITS = 4
);
  logic              load;
  logic [W-1:0]      value;
  logic              busy;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  modport master(output load, value, input busy, seg, an);
  modport slave(input load, value, output busy, seg, an);
endinterface

// File: rtl/ou_display.sv
// ou_display: captures a signed result on load, converts |value| to BCD (shift-add-3) and scans a common-anode 7-seg display; ports CLK, CLR (async active-low), bus.load/value in, bus.busy/seg/an out; LZB_EN enables leading-zero blanking
module ou_display #(
  parameter int W = 8,
  parameter int DIGITS = 4,
  parameter int PRESCALE = 50000
) (
  input logic         CLK,
  input logic         CLR,
  ou_display_if.slave bus
);
  localparam int BW = 4 * (DIGITS - 1);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] ZERO = 7'b1000000;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
  state_t            r_state;
  logic              r_busy, r_wsign, r_sign;
  logic [W-1:0]      r_mag, w_mag;
  logic [BW-1:0]     r_bcd, r_disp, w_adj;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx, w_nidx;
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg, w_seg;
  logic              w_wrap;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = BLANK;
    endcase
  endfunction

  // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude
  assign w_mag = bus.value[W-1] ? ~bus.value + 1'b1 : bus.value;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS - 1; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_wsign <= 1'b0;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_disp  <= '0;
      r_cnt   <= '0;
    end else
      case (r_state)
        IDLE:
          if (bus.load) begin
            r_wsign <= bus.value[W-1] && |w_mag;
            r_mag   <= w_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CONVERT;
          end
        CONVERT: begin
          {r_bcd, r_mag} <= {w_adj[BW-2:0], r_mag, 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= COMMIT;
        end
        COMMIT: begin
          r_disp  <= r_bcd;
          r_sign  <= r_wsign;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

  assign w_wrap = r_pre == PW'(PRESCALE - 1);
  assign w_nidx = r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1;

  // segment pattern for the digit about to be enabled
  always_comb begin
    w_seg = r_sign ? DASH : BLANK;
    for (int i = 0; i < DIGITS - 1; i++)
      if (w_nidx == IW'(i))
`ifdef LZB_EN
        w_seg = (i > 0 && ~|(r_disp >> (4 * i))) ? BLANK : glyph(r_disp[4*i +: 4]);
`else
        w_seg = glyph(r_disp[4*i +: 4]);
`endif
  end

  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= ~DIGITS'(1);
      r_seg <= ZERO;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_idx <= w_nidx;
      r_an  <= ~(DIGITS'(1) << w_nidx);
      r_seg <= w_seg;
    end else
      r_pre <= r_pre + 1'b1;

  assign bus.busy = r_busy;
  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
endmodule

// File: tb/tb_ou_display.sv
// tb_ou_display: directed scoreboard bench for ou_display (W=8, DIGITS=4, PRESCALE=4)
module tb_ou_display;
  localparam int W = 8;
  localparam int DIGITS = 4;
  localparam int PRESCALE = 4;
  logic CLK = 1'b0;
  logic CLR = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  int rises = 0;
  logic [27:0] sb[$];
  logic [27:0] shown;

  ou_display_if #(.W(W), .DIGITS(DIGITS)) bus ();
  ou_display #(.W(W), .DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge bus.busy) rises++;

  function automatic logic [6:0] g(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // expected glyphs {sign, hundreds, tens, units}
  function automatic logic [27:0] model(input logic [7:0] v);
    int m;
    logic [6:0] s1, s2;
    m = v[7] ? 256 - int'(v) : int'(v);
    s2 = g(m / 100);
    s1 = g((m / 10) % 10);
`ifdef LZB_EN
    if (m < 100) s2 = 7'h7F;
    if (m < 10) s1 = 7'h7F;
`endif
    return {(v[7] ? 7'b0111111 : 7'h7F), s2, s1, g(m % 10)};
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    logic [3:0] oh;
    idx_of = -1;
    for (int i = 0; i < 4; i++) begin
      oh = ~(4'b0001 << i);
      if (a === oh) idx_of = i;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic chk_cur(input string tag);
    int k;
    k = idx_of(bus.an);
    chk({tag, "_an"}, k >= 0, 1);
    if (k >= 0) chk({tag, "_seg"}, bus.seg, shown[7*k +: 7]);
  endtask

  task automatic check_scan(input string tag, input logic [27:0] exp);
    logic [3:0] prev;
    int t;
    int k;
    for (int d = 0; d < 4; d++) begin
      prev = bus.an;
      t = 0;
      while (bus.an === prev && t < 2 * PRESCALE + 2) begin
        @(negedge CLK);
        t++;
      end
      k = idx_of(bus.an);
      chk({tag, "_scan_an"}, k >= 0, 1);
      if (k >= 0) chk({tag, "_scan_seg"}, bus.seg, exp[7*k +: 7]);
    end
  endtask

  task automatic load_val(input logic [7:0] v, input bit push);
    @(negedge CLK);
    bus.load = 1'b1;
    bus.value = v;
    if (push) sb.push_back(model(v));
    @(negedge CLK);
    bus.load = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] v, input int inj);
    logic [27:0] exp;
    int n;
    int r0;
    r0 = rises;
    load_val(v, 1'b1);
    chk({tag, "_busy_on"}, bus.busy, 1);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (n == 2) chk_cur({tag, "_hold"});
      if (n == inj) begin
        bus.load = 1'b1;
        bus.value = 8'd99;
      end
      @(negedge CLK);
      bus.load = 1'b0;
      n++;
    end
    chk({tag, "_busy_len"}, n, 9);
    if (inj >= 0) begin
      repeat (12) @(negedge CLK);
      chk({tag, "_no_requeue"}, bus.busy, 0);
    end
    chk({tag, "_one_rise"}, rises - r0, 1);
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check_scan(tag, exp);
      shown = exp;
    end
  endtask

  initial begin
    logic [27:0] rst_exp;
    logic [3:0] exp_an;
    int r0;
    bus.load = 1'b0;
    bus.value = '0;
    rst_exp = model(8'd0);
    repeat (3) @(negedge CLK);
    chk("in_reset_busy", bus.busy, 0);
    chk("in_reset_an", bus.an, 4'b1110);
    chk("in_reset_seg", bus.seg, 7'b1000000);
    CLR = 1'b1;
    for (int j = 0; j < 16; j++) begin
      #1;
      exp_an = ~(4'b0001 << (j / 4));
      chk("rst_an", bus.an, exp_an);
      chk("rst_seg", bus.seg, rst_exp[7*(j/4) +: 7]);
      chk("rst_busy", bus.busy, 0);
      @(negedge CLK);
    end
    shown = rst_exp;
    run("v123", 8'd123, -1);
    run("vm128", 8'h80, -1);
    run("vm1", 8'hFF, -1);
    run("v127", 8'd127, -1);
    run("v0", 8'd0, -1);
    run("v5_ign99", 8'd5, 3);
    load_val(8'd77, 1'b0);
    repeat (3) @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_an", bus.an, 4'b1110);
    chk("abort_seg", bus.seg, 7'b1000000);
    @(negedge CLK);
    CLR = 1'b1;
    r0 = rises;
    repeat (20) @(negedge CLK);
    chk("abort_no_rise", rises, r0);
    chk("abort_idle", bus.busy, 0);
    check_scan("abort", rst_exp);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
